// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache feeding the fetch queue: zero-latency hit path,
// single-outstanding line refill from backing memory, saturating hit/miss counters.
module icache_fetch #(
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int NUM_LINES        = 16,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       PC_in,
  input  logic                        rd_en,
  input  logic                        abort,
  input  logic                        invalidate,
  output logic [CACHE_LINE_WIDTH-1:0] D_out,
  output logic                        d_out_valid,
  output logic                        stall,
  output logic                        mem_req,
  output logic [DATA_WIDTH-1:0]       mem_addr,
  input  logic                        mem_gnt,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        mem_rvalid,
  output logic [CNT_WIDTH-1:0]        hit_count,
  output logic [CNT_WIDTH-1:0]        miss_count
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = DATA_WIDTH - 4 - INDEX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;

  state_e                        state_q;
  logic [NUM_LINES-1:0]          valid_q;
  logic [TAG_W-1:0]              tag_q  [NUM_LINES];
  logic [CACHE_LINE_WIDTH-1:0]   data_q [NUM_LINES];
  logic [3*DATA_WIDTH-1:0]       line_buf_q;
  logic [1:0]                    beat_cnt_q;
  logic                          drop_q;
  logic                          mem_req_q;
  logic [DATA_WIDTH-1:0]         mem_addr_q;
  logic [CNT_WIDTH-1:0]          hit_count_q;
  logic [CNT_WIDTH-1:0]          miss_count_q;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               lookup;
  logic               fill_beat;
  logic               fill_done;
  logic               unused_pc_bits;

  assign index          = PC_in[4 +: INDEX_W];
  assign tag            = PC_in[4+INDEX_W +: TAG_W];
  assign fill_idx       = mem_addr_q[4 +: INDEX_W];
  assign fill_tag       = mem_addr_q[4+INDEX_W +: TAG_W];
  assign unused_pc_bits = ^PC_in[3:0];

  assign hit       = valid_q[index] & (tag_q[index] == tag);
  assign lookup    = (state_q == IDLE) & rd_en & ~abort;
  // Beats are gated by rst so a reset landing on the final beat cannot install a half-filled line.
  assign fill_beat = rst & (state_q == FILL) & mem_rvalid;
  assign fill_done = fill_beat & (beat_cnt_q == 2'd3);

  assign d_out_valid = rst & lookup & hit;
  assign D_out       = d_out_valid ? data_q[index] : '0;
  assign stall       = rst & ((state_q != IDLE) | (rd_en & ~hit));
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      beat_cnt_q   <= '0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (lookup && hit && (hit_count_q != '1)) hit_count_q <= hit_count_q + CNT_WIDTH'(1);

      case (state_q)
        IDLE: begin
          if (lookup && !hit) begin
            if (miss_count_q != '1) miss_count_q <= miss_count_q + CNT_WIDTH'(1);
            mem_addr_q <= {PC_in[DATA_WIDTH-1:4], 4'b0};
            mem_req_q  <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (invalidate) drop_q <= 1'b1;
          if (mem_gnt) begin
            mem_req_q  <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (invalidate) drop_q <= 1'b1;
          if (mem_rvalid) begin
            beat_cnt_q <= beat_cnt_q + 2'd1;
            if (beat_cnt_q == 2'd3) begin
              drop_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // A coincident invalidate wins over the install, leaving the new line invalid.
      if (invalidate)                valid_q           <= '0;
      else if (fill_done && !drop_q) valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays and the line buffer carry no reset; the valid bits alone
  // decide whether their contents are ever observed.
  always_ff @(posedge clk) begin
    if (fill_beat) begin
      case (beat_cnt_q)
        2'd0:    line_buf_q[DATA_WIDTH-1:0]              <= mem_rdata;
        2'd1:    line_buf_q[2*DATA_WIDTH-1:DATA_WIDTH]   <= mem_rdata;
        2'd2:    line_buf_q[3*DATA_WIDTH-1:2*DATA_WIDTH] <= mem_rdata;
        default: ;
      endcase
    end
    if (fill_done) begin
      data_q[fill_idx] <= {mem_rdata, line_buf_q};
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: a transaction-level cache model checked every
// cycle, plus literal expectations on the key scenarios.
module tb_icache_fetch;

  localparam int DW = 32;
  localparam int CLW = 128;
  localparam int NL = 16;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [DW-1:0]  PC_in = '0;
  logic           rd_en = 1'b0;
  logic           abort = 1'b0;
  logic           invalidate = 1'b0;
  logic [CLW-1:0] D_out;
  logic           d_out_valid;
  logic           stall;
  logic           mem_req;
  logic [DW-1:0]  mem_addr;
  logic           mem_gnt = 1'b0;
  logic [DW-1:0]  mem_rdata = '0;
  logic           mem_rvalid = 1'b0;
  logic [CW-1:0]  hit_count;
  logic [CW-1:0]  miss_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  icache_fetch #(
    .DATA_WIDTH(DW), .CACHE_LINE_WIDTH(CLW), .NUM_LINES(NL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .PC_in(PC_in), .rd_en(rd_en), .abort(abort),
    .invalidate(invalidate), .D_out(D_out), .d_out_valid(d_out_valid),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cache contents per line plus one outstanding refill transaction.
  bit             m_known = 1'b0;
  bit             m_busy, m_granted, m_drop;
  logic [31:0]    m_addr;
  int             m_beats;
  logic [31:0]    m_buf [3];
  bit             m_valid [NL];
  logic [27:0]    m_tag [NL];
  logic [127:0]   m_data [NL];
  int             m_hits, m_misses;
  bit             m_set_drop;
  int             m_idx;

  function automatic bit m_hit();
    int i;
    i = int'(PC_in[7:4]);
    return m_valid[i] && (m_tag[i] == PC_in[31:4]);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_known = 1'b1;
      m_busy = 1'b0; m_granted = 1'b0; m_drop = 1'b0; m_beats = 0;
      m_hits = 0; m_misses = 0;
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    end else if (m_known) begin
      m_set_drop = invalidate && m_busy;
      if (invalidate)
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      if (!m_busy) begin
        if (rd_en && !abort) begin
          if (m_hit()) begin
            if (m_hits < CNT_MAX) m_hits++;
          end else begin
            if (m_misses < CNT_MAX) m_misses++;
            m_busy = 1'b1; m_granted = 1'b0; m_beats = 0;
            m_addr = {PC_in[31:4], 4'h0};
          end
        end
      end else if (!m_granted) begin
        if (mem_gnt) m_granted = 1'b1;
      end else if (mem_rvalid) begin
        if (m_beats < 3) begin
          m_buf[m_beats] = mem_rdata;
          m_beats++;
        end else begin
          m_idx = int'(m_addr[7:4]);
          m_data[m_idx] = {mem_rdata, m_buf[2], m_buf[1], m_buf[0]};
          m_tag[m_idx]  = m_addr[31:4];
          if (!m_drop && !invalidate) m_valid[m_idx] = 1'b1;
          m_drop = 1'b0;
          m_busy = 1'b0;
        end
      end
      if (m_set_drop && m_busy) m_drop = 1'b1;
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (m_known) begin
      logic         e_dv;
      logic         e_stall;
      logic [127:0] e_line;
      e_dv    = rst && !m_busy && rd_en && !abort && m_hit();
      e_stall = rst && (m_busy || (rd_en && !m_hit()));
      e_line  = e_dv ? m_data[int'(PC_in[7:4])] : 128'h0;
      check("cyc_d_out_valid", d_out_valid, e_dv);
      check("cyc_D_out", D_out, e_line);
      check("cyc_stall", stall, e_stall);
      check("cyc_mem_req", mem_req, m_busy && !m_granted);
      if (m_busy && !m_granted) check("cyc_mem_addr", mem_addr, m_addr);
      check("cyc_hit_count", hit_count, m_hits);
      check("cyc_miss_count", miss_count, m_misses);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in the first REQ cycle; returns in the first IDLE cycle after the fill.
  task automatic fill_line(input logic [31:0] addr, input logic [31:0] base,
                           input int gnt_wait, input int abort_beat, input int inv_beat);
    for (int i = 0; i < gnt_wait; i++) begin
      #2;
      check("wait_mem_req", mem_req, 1'b1);
      check("wait_mem_addr", mem_addr, addr);
      cyc();
    end
    #2;
    check("req_mem_req", mem_req, 1'b1);
    check("req_mem_addr", mem_addr, addr);
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        cyc();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(b);
      abort      = (b == abort_beat);
      invalidate = (b == inv_beat);
      cyc();
    end
    mem_rvalid = 1'b0; mem_rdata = '0; abort = 1'b0; invalidate = 1'b0;
  endtask

  task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] base, input int gnt_wait,
                            input int abort_beat);
    logic [127:0] line;
    line = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    PC_in = pc; rd_en = 1'b1; abort = 1'b0;
    #2;
    check("miss_stall", stall, 1'b1);
    check("miss_dv", d_out_valid, 1'b0);
    cyc();
    fill_line({pc[31:4], 4'h0}, base, gnt_wait, abort_beat, -1);
    #2;
    check("deliver_dv", d_out_valid, 1'b1);
    check("deliver_line", D_out, line);
    cyc();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    #2;
    check("rst_dv", d_out_valid, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_hits", hit_count, 16'd0);
    check("rst_misses", miss_count, 16'd0);
    rst = 1'b1;
    cyc();

    // Cold miss on 0x100
    PC_in = 32'h100; rd_en = 1'b1;
    #2;
    check("cold_stall", stall, 1'b1);
    check("cold_mem_req_early", mem_req, 1'b0);
    cyc();
    fill_line(32'h100, 32'hA0, 0, -1, -1);
    #2;
    check("cold_dv", d_out_valid, 1'b1);
    check("cold_line", D_out, 128'h000000A3_000000A2_000000A1_000000A0);
    check("cold_misses", miss_count, 16'd1);
    cyc();
    rd_en = 1'b0;
    #2;
    check("cold_hits", hit_count, 16'd1);
    cyc();

    // Hit streaming
    fetch_miss(32'h110, 32'hB0, 0, -1);
    PC_in = 32'h100; rd_en = 1'b1;
    #2;
    check("stream0_stall", stall, 1'b0);
    check("stream0_line", D_out, 128'h000000A3_000000A2_000000A1_000000A0);
    cyc();
    PC_in = 32'h110;
    #2;
    check("stream1_line", D_out, 128'h000000B3_000000B2_000000B1_000000B0);
    cyc();
    PC_in = 32'h104;
    #2;
    check("stream2_dv", d_out_valid, 1'b1);
    check("stream2_line", D_out, 128'h000000A3_000000A2_000000A1_000000A0);
    cyc();
    rd_en = 1'b0;
    #2;
    check("stream_hits", hit_count, 16'd5);
    check("stream_misses", miss_count, 16'd2);
    cyc();

    // Conflict eviction on index 0
    fetch_miss(32'h200, 32'hC0, 0, -1);
    fetch_miss(32'h100, 32'hD0, 0, -1);
    #2;
    check("conflict_misses", miss_count, 16'd4);
    check("conflict_hits", hit_count, 16'd7);
    cyc();

    // Abort on a hit and on a miss in IDLE
    PC_in = 32'h100; rd_en = 1'b1; abort = 1'b1;
    #2;
    check("abort_hit_dv", d_out_valid, 1'b0);
    cyc();
    PC_in = 32'h300;
    #2;
    check("abort_miss_stall", stall, 1'b1);
    cyc();
    abort = 1'b0; rd_en = 1'b0;
    #2;
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_hits", hit_count, 16'd7);
    check("abort_misses", miss_count, 16'd4);
    cyc();

    // Abort during FILL: line still installed and delivered
    fetch_miss(32'h120, 32'hE0, 1, 2);

    // Invalidate during beat 1: refilled line stays invalid, second request issued
    PC_in = 32'h130; rd_en = 1'b1;
    cyc();
    fill_line(32'h130, 32'hF0, 0, -1, 1);
    #2;
    check("drop_dv", d_out_valid, 1'b0);
    check("drop_stall", stall, 1'b1);
    cyc();
    fill_line(32'h130, 32'hF4, 0, -1, -1);
    #2;
    check("drop_refill_line", D_out, 128'h000000F7_000000F6_000000F5_000000F4);
    cyc();
    rd_en = 1'b0;
    fetch_miss(32'h100, 32'h10, 0, -1);

    // Invalidate in IDLE: all lines miss afterwards
    invalidate = 1'b1;
    cyc();
    invalidate = 1'b0; abort = 1'b1; rd_en = 1'b1; PC_in = 32'h110;
    #2;
    check("inv_idle_110_stall", stall, 1'b1);
    cyc();
    PC_in = 32'h100;
    #2;
    check("inv_idle_100_stall", stall, 1'b1);
    cyc();
    abort = 1'b0;

    // Invalidate coinciding with the completing beat
    PC_in = 32'h130;
    cyc();
    fill_line(32'h130, 32'h20, 0, -1, 3);
    #2;
    check("inv_last_dv", d_out_valid, 1'b0);
    cyc();
    fill_line(32'h130, 32'h24, 0, -1, -1);
    #2;
    check("inv_last_refill_dv", d_out_valid, 1'b1);
    check("inv_last_misses", miss_count, 16'd10);
    cyc();
    rd_en = 1'b0;
    #2;
    check("inv_last_hits", hit_count, 16'd11);
    cyc();

    // Grant wait then reset after beat 2
    PC_in = 32'h100; rd_en = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #2;
      check("gwait_mem_req", mem_req, 1'b1);
      check("gwait_mem_addr", mem_addr, 32'h100);
      cyc();
    end
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h50 + 32'(b);
      cyc();
    end
    mem_rvalid = 1'b0;
    rst = 1'b0; rd_en = 1'b0;
    #2;
    check("midrst_stall", stall, 1'b0);
    check("midrst_dv", d_out_valid, 1'b0);
    cyc();
    rst = 1'b1;
    #2;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_misses", miss_count, 16'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    cyc();
    mem_rvalid = 1'b0;
    #2;
    check("stray_mem_req", mem_req, 1'b0);
    check("stray_stall", stall, 1'b0);
    cyc();
    fetch_miss(32'h100, 32'h60, 2, -1);
    #2;
    check("final_misses", miss_count, 16'd1);
    check("final_hits", hit_count, 16'd1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL timeout: simulation exceeded its time budget");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache with line-refill FSM, directly upstream of the instruction fetch queue.
- Consumes the fetch PC and fetch enable, and returns one 128-bit line (four instructions) with a valid strobe.
- On a miss it raises stall, fetches the line from backing memory as four 32-bit beats, installs it, then delivers it.
- Keeps saturating hit and miss counters for performance analysis.

Parameters:
DATA_WIDTH, 32, address/instruction word width
CACHE_LINE_WIDTH, 128, line width; fixed at 4 words
NUM_LINES, 16, number of lines (power of 2); INDEX_W = log2(NUM_LINES)
CNT_WIDTH, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
PC_in  in  DATA_WIDTH  fetch address (byte); bits [3:0] ignored
rd_en  in  1  fetch request this cycle
abort  in  1  jump/branch redirect; suppresses delivery this cycle
invalidate  in  1  clear all valid bits (fence.i)
D_out  out  CACHE_LINE_WIDTH  line for PC_in; word0 in [31:0]
d_out_valid  out  1  D_out valid this cycle
stall  out  1  upstream must hold PC_in and must not advance
mem_req  out  1  line-fill request
mem_addr  out  DATA_WIDTH  line-aligned fill address
mem_gnt  in  1  memory accepted request
mem_rdata  in  DATA_WIDTH  fill beat data
mem_rvalid  in  1  fill beat valid; beats arrive in order, word0 first
hit_count  out  CNT_WIDTH  lookups that hit
miss_count  out  CNT_WIDTH  lookups that missed

Behaviour:
- Address split: index = PC_in[4+INDEX_W-1:4]; tag = PC_in[DATA_WIDTH-1:4+INDEX_W].
- Storage: valid bits and tags in flops. Data array is read combinationally.
- FSM states: IDLE, REQ, FILL.
- IDLE, hit definition: hit = valid[index] & (tag_mem[index] == tag).
- IDLE, hit output: d_out_valid = rd_en & hit & ~abort, in the same cycle (0-cycle latency). D_out = data[index].
- IDLE, miss: on rd_en & ~hit & ~abort, latch miss_addr = {PC_in[DATA_WIDTH-1:4], 4'b0} and go to REQ.
- Stall: stall = (state != IDLE) | (rd_en & ~hit). It is combinational, so stall is high in the miss cycle.
- REQ: mem_req = 1 and mem_addr = miss_addr, both held until mem_gnt = 1. Then clear beat_cnt and go to FILL.
- FILL, beat capture: each mem_rvalid writes mem_rdata into line_buf word[beat_cnt] and increments beat_cnt (2 bits).
- FILL, completion: on the beat with beat_cnt == 3, write {beat3, line_buf[2:0]} to data[idx], write tag_mem[idx], set valid[idx] unless drop_flag is set, then go to IDLE.
- After a fill: the next IDLE cycle re-looks-up the held PC_in and hits. Miss-to-delivery latency = 1 + grant wait + beat latency + 4 beats + 1.
- mem_rvalid outside FILL is ignored.
- D_out when d_out_valid = 0: forced to 0.
- abort:
  - In IDLE it forces d_out_valid = 0 and suppresses miss detection and counting.
  - During REQ/FILL the fill is not cancelled. The line is installed, and the new PC_in is looked up on return to IDLE.
- invalidate:
  - Clears all valid bits next edge.
  - If it is asserted during REQ/FILL, drop_flag is set. The filled line is written but left invalid, and drop_flag clears on entering IDLE.
  - If invalidate coincides with the completing beat, the valid bit is not set.
- Counters:
  - hit_count increments on a cycle with IDLE & rd_en & ~abort & hit.
  - miss_count increments on the IDLE miss-detection cycle only (once per miss).
  - Both saturate at all-ones.
- Reset (rst == 0 at an edge):
  - state = IDLE, all valid = 0, beat_cnt = 0, drop_flag = 0, counters = 0, mem_req = 0, mem_addr = 0.
  - Tag and data arrays are not reset.
  - Reset mid-fill abandons the line; later stray beats are ignored.
- Outputs under reset: d_out_valid = 0 and stall = 0 while rst is low.

Test Plan:
- Cold miss: reset; PC_in = 0x100, rd_en = 1 → stall = 1, mem_req with mem_addr = 0x100. Grant plus beats 0xA0..0xA3 → next cycle d_out_valid = 1, D_out = {0xA3,0xA2,0xA1,0xA0}, miss_count = 1, hit_count = 1.
- Hit streaming: after filling 0x100 and 0x110, fetch 0x100, 0x110, 0x104 back-to-back → d_out_valid each cycle, stall = 0, hit_count += 3.
- Conflict eviction: fill 0x100, then fetch 0x200 (same index 0, NUM_LINES = 16) → miss and refill. Re-fetch 0x100 → miss again; miss_count = 3.
- Abort: hit cycle with abort = 1 → d_out_valid = 0, no counter change. abort during FILL → fill completes and line 0x100 becomes valid.
- Invalidate during FILL: assert invalidate in beat 1 → after fill, lookup of 0x100 misses (second mem_req). Invalidate in IDLE → all subsequent lookups miss.
- Reset mid-fill and grant wait: hold mem_gnt = 0 for 5 cycles → mem_req and mem_addr stable. Reset after beat 2 → state IDLE, outputs at reset values, stray mem_rvalid ignored, 0x100 still misses.
